hpgp_tx_intlv_ctrl: RTL and testbench

//  TX-side turbo block interleaver controller: accepts a stream of D_WIDTH-bit symbols, writes each block of

---
 rtl/hpgp_tx_intlv_ctrl_if.sv | 35 +++
 rtl/hpgp_tx_intlv_ctrl.sv | 151 +++++++++++++++
 tb/tb_hpgp_tx_intlv_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpgp_tx_intlv_ctrl_if.sv
// hpgp_tx_intlv_ctrl_if
//   Bundles the three buses of the TX interleaver controller: the symbol
//   input stream, the interleaved output stream and the external 2-port RAM.
//   master : controller side (drives in_ready, out_*, mem_* except mem_rdata)
//   slave  : environment side (encoder, mapper and RAM)
interface hpgp_tx_intlv_ctrl_if #(
    parameter int D_WIDTH = 2,
    parameter int A_WIDTH = 8
);
    logic [D_WIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [D_WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic [A_WIDTH-1:0] mem_waddr;
    logic               mem_wen;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [A_WIDTH-1:0] mem_raddr;
    logic               mem_ren;
    logic [D_WIDTH-1:0] mem_rdata;

    modport master (
        input  in_data, in_valid, out_ready, mem_rdata,
        output in_ready, out_data, out_valid, out_last,
               mem_waddr, mem_wen, mem_wdata, mem_raddr, mem_ren
    );

    modport slave (
        output in_data, in_valid, out_ready, mem_rdata,
        input  in_ready, out_data, out_valid, out_last,
               mem_waddr, mem_wen, mem_wdata, mem_raddr, mem_ren
    );
endinterface

// File: rtl/hpgp_tx_intlv_ctrl.sv
// hpgp_tx_intlv_ctrl
//   TX turbo block interleaver controller. Symbols are written row-wise into
//   one bank of an external 2-port RAM while the other bank is read back
//   column-wise (ping-pong). Read data is buffered in a 2-entry skid FIFO so
//   the output sustains one symbol per cycle and holds steady under stall.
// Ports
//   clk    : clock, posedge
//   n_rst  : asynchronous active-low reset
//   bypass : (only with HPGP_TX_INTLV_BYPASS_EN) read block sequentially,
//            sampled when the reader starts a block
//   bus    : master modport of hpgp_tx_intlv_ctrl_if (in/out streams, RAM)
// Configuration macro: HPGP_TX_INTLV_BYPASS_EN
module hpgp_tx_intlv_ctrl #(
    parameter int D_WIDTH = 2,
    parameter int ROWS    = 8,
    parameter int COLS    = 16,
    parameter int A_WIDTH = 8
) (
    input logic clk,
    input logic n_rst,
`ifdef HPGP_TX_INTLV_BYPASS_EN
    input logic bypass,
`endif
    hpgp_tx_intlv_ctrl_if.master bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = A_WIDTH - 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic          wr_bank, rd_bank;
    logic [1:0]    full;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] acc;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [IW-1:0] rd_addr;

    logic          wr_fire, rd_fire, rd_last, pop, credit_ok;
    logic [1:0]    fifo_cnt, occ;
    logic [1:0][D_WIDTH-1:0] fifo_data;
    logic [1:0]    fifo_last;
    logic          wptr, rptr;
    logic          infl, infl_last;

    // ---------------- write side ----------------
    assign wr_fire       = bus.in_valid && !full[wr_bank];
    assign bus.in_ready  = !full[wr_bank];
    assign bus.mem_wen   = wr_fire;
    assign bus.mem_waddr = {wr_bank, wr_idx};
    assign bus.mem_wdata = bus.in_data;

    // ---------------- read side -----------------
    assign pop     = (fifo_cnt != 2'd0) && bus.out_ready;
    assign occ     = fifo_cnt + {1'b0, infl};
    // A pop in this cycle frees a slot in time for the read issued now.
    assign credit_ok = (occ < 2'd2) || pop;
    assign rd_fire = full[rd_bank] && credit_ok;
    assign rd_last = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

`ifdef HPGP_TX_INTLV_BYPASS_EN
    logic [IW-1:0] seq;
    logic          byp_q, byp_now;
    // At block start the live port value decides; afterwards the latched one.
    assign byp_now = (seq == '0) ? bypass : byp_q;
    assign rd_addr = byp_now ? seq : acc;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            seq   <= '0;
            byp_q <= 1'b0;
        end else if (rd_fire) begin
            if (seq == '0) byp_q <= bypass;
            seq <= rd_last ? '0 : seq + IW'(1);
        end
    end
`else
    assign rd_addr = acc;
`endif

    assign bus.mem_ren   = rd_fire;
    assign bus.mem_raddr = {rd_bank, rd_addr};

    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_data  = fifo_data[rptr];
    assign bus.out_last  = fifo_last[rptr] && bus.out_valid;

    // Bank state and counters. The writer only sets and the reader only
    // clears full[], always on different banks in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            full    <= 2'b00;
            rd_bank <= 1'b0;
            row     <= '0;
            col     <= '0;
            acc     <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_idx == IW'(N - 1)) begin
                    wr_idx        <= '0;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end
            if (rd_fire) begin
                if (rd_last) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    row           <= '0;
                    col           <= '0;
                    acc           <= '0;
                end else if (row == RW'(ROWS - 1)) begin
                    // column done: next column starts at address col+1
                    row <= '0;
                    col <= col + CW'(1);
                    acc <= IW'(col) + IW'(1);
                end else begin
                    row <= row + RW'(1);
                    acc <= acc + IW'(COLS);
                end
            end
        end
    end

    // Skid FIFO: RAM data arrives the cycle after issue and is pushed then.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fifo_data <= '0;
            fifo_last <= 2'b00;
            fifo_cnt  <= 2'd0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            infl      <= 1'b0;
            infl_last <= 1'b0;
        end else begin
            infl      <= rd_fire;
            infl_last <= rd_fire && rd_last;
            if (infl) begin
                fifo_data[wptr] <= bus.mem_rdata;
                fifo_last[wptr] <= infl_last;
                wptr            <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            fifo_cnt <= fifo_cnt + {1'b0, infl} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_hpgp_tx_intlv_ctrl.sv
module tb_hpgp_tx_intlv_ctrl;
    localparam int DW = 4, R = 4, C = 3, AW = 5, N = R * C;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    hpgp_tx_intlv_ctrl_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

    logic use_byp = 1'b0;
`ifdef HPGP_TX_INTLV_BYPASS_EN
    hpgp_tx_intlv_ctrl #(.D_WIDTH(DW), .ROWS(R), .COLS(C), .A_WIDTH(AW)) dut (
        .clk(clk), .n_rst(n_rst), .bypass(use_byp), .bus(bus));
`else
    hpgp_tx_intlv_ctrl #(.D_WIDTH(DW), .ROWS(R), .COLS(C), .A_WIDTH(AW)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus));
`endif

    // external 2-port RAM, 1-cycle read latency
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (bus.mem_wen) ram[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [DW-1:0] d; logic l; } sym_t;
    logic [DW-1:0] cur_blk[$];
    sym_t exp_q[$];
    sym_t obs[$];
    int   out_cyc[$];
    int   blk_cnt = 0;
    int   n_in = 0, n_out = 0;
    logic mon_en = 1'b0;

    // Whole block known: emit its symbols in read order.
    function automatic void build_block();
        sym_t s;
        if (use_byp) begin
            for (int i = 0; i < N; i++) begin
                s.d = cur_blk[i]; s.l = (i == N - 1); exp_q.push_back(s);
            end
        end else begin
            for (int c = 0; c < C; c++)
                for (int r = 0; r < R; r++) begin
                    s.d = cur_blk[r * C + c];
                    s.l = (c == C - 1) && (r == R - 1);
                    exp_q.push_back(s);
                end
        end
        cur_blk.delete();
        blk_cnt++;
    endfunction

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    always @(negedge clk) begin
        if (n_rst && mon_en) begin
            if (bus.in_valid && bus.in_ready) begin
                logic [AW-1:0] ea;
                ea = AW'(cur_blk.size());
                ea[AW-1] = blk_cnt[0];
                chk("mem_wen_on_accept", 32'(bus.mem_wen), 32'd1);
                chk("mem_waddr", 32'(bus.mem_waddr), 32'(ea));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.in_data));
                cur_blk.push_back(bus.in_data);
                n_in++;
                if (cur_blk.size() == N) build_block();
            end else begin
                chk("mem_wen_idle", 32'(bus.mem_wen), 32'd0);
            end
            if (prev_stall) begin
                chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
                chk("stall_data_held", 32'(bus.out_data), 32'(prev_d));
                chk("stall_last_held", 32'(bus.out_last), 32'(prev_l));
            end
            if (bus.out_valid && bus.out_ready) begin
                sym_t s, o;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    s = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(s.d));
                    chk("out_last", 32'(bus.out_last), 32'(s.l));
                end
                o.d = bus.out_data; o.l = bus.out_last;
                obs.push_back(o);
                out_cyc.push_back(cyc);
                n_out++;
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_d     <= bus.out_data;
            prev_l     <= bus.out_last;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int stall_cnt = 0;

    // Called at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic send(input logic [DW-1:0] d);
        int k;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            stall_cnt++;
        end
        if (k == 2000) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0 && cur_blk.size() == 0 && !bus.out_valid) break;
            @(posedge clk); #1;
        end
        if (k == 3000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        chk({tag, "_mem_wen"},   32'(bus.mem_wen),   32'd0);
        chk({tag, "_mem_ren"},   32'(bus.mem_ren),   32'd0);
        chk({tag, "_mem_waddr"}, 32'(bus.mem_waddr), 32'd0);
        chk({tag, "_mem_raddr"}, 32'(bus.mem_raddr), 32'd0);
    endtask

    typedef struct { logic [DW-1:0] din; logic [DW-1:0] dout; logic last; } vec_t;
    vec_t tbl[N];

    task automatic check_table(input string tag);
        chk({tag, "_count"}, 32'(obs.size()), 32'(N));
        for (int i = 0; i < N && i < obs.size(); i++) begin
            chk({tag, "_data"}, 32'(obs[i].d), 32'(tbl[i].dout));
            chk({tag, "_last"}, 32'(obs[i].l), 32'(tbl[i].last));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int ord[N] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
        int base;
        logic done;
        for (int i = 0; i < N; i++) begin
            tbl[i].din  = DW'(i);
            tbl[i].dout = DW'(ord[i]);
            tbl[i].last = (i == N - 1);
        end
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        // reset state
        cycles(2);
        check_reset_outputs("reset");
        n_rst = 1'b1; mon_en = 1'b1;
        cycles(1);

        // basic interleave, latency and output rate
        obs.delete();
        for (int i = 0; i < N; i++) send(tbl[i].din);
        chk("lat_ren_after_accept", 32'(bus.mem_ren), 32'd1);
        chk("lat_valid_e0", 32'(bus.out_valid), 32'd0);
        cycles(1);
        chk("lat_valid_e1", 32'(bus.out_valid), 32'd0);
        cycles(1);
        chk("lat_valid_e2", 32'(bus.out_valid), 32'd1);
        wait_drain();
        check_table("interleave");
        chk("interleave_rate", 32'(out_cyc[$] - out_cyc[0]), 32'(N - 1));

        // ping-pong with downstream blocked
        bus.out_ready = 1'b0;
        base = n_in;
        for (int i = 0; i < 2 * N; i++) send(DW'(i));
        chk("pp_accepted", 32'(n_in - base), 32'(2 * N));
        chk("pp_in_ready_now", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1; bus.in_data = DW'(2 * N);
        cycles(10);
        chk("pp_in_ready_later", 32'(bus.in_ready), 32'd0);
        chk("pp_accepted_held", 32'(n_in - base), 32'(2 * N));
        base = n_out;
        bus.out_ready = 1'b1;
        for (int i = 2 * N; i < 3 * N; i++) send(DW'(i));
        wait_drain();
        chk("pp_out_count", 32'(n_out - base), 32'(3 * N));

        // random backpressure
        obs.delete();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    send(tbl[i].din);
                    if ($urandom_range(0, 3) == 0) cycles(1);
                end
                for (int i = 0; i < 2 * N; i++) begin
                    send(DW'($urandom));
                    if ($urandom_range(0, 3) == 0) cycles(1);
                end
                wait_drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                end
                bus.out_ready = 1'b1;
            end
        join
        obs = obs[0:N-1];
        check_table("backpressure");

        // throughput
        obs.delete(); out_cyc.delete();
        stall_cnt = 0;
        for (int i = 0; i < 4 * N; i++) send(DW'($urandom));
        wait_drain();
        chk("tp_in_stalls", 32'(stall_cnt), 32'd0);
        chk("tp_out_count", 32'(out_cyc.size()), 32'(4 * N));
        chk("tp_out_span", 32'(out_cyc[$] - out_cyc[0]), 32'(4 * N - 1));

        // reset in the middle of traffic
        bus.out_ready = 1'b0;
        for (int i = 0; i < N + 5; i++) send(DW'($urandom));
        n_rst = 1'b0; mon_en = 1'b0;
        #2;
        check_reset_outputs("midrst");
        cur_blk.delete(); exp_q.delete(); blk_cnt = 0;
        cycles(2);
        n_rst = 1'b1; mon_en = 1'b1; bus.out_ready = 1'b1;
        cycles(1);
        obs.delete();
        for (int i = 0; i < N; i++) send(tbl[i].din);
        wait_drain();
        check_table("after_reset");

`ifdef HPGP_TX_INTLV_BYPASS_EN
        // sequential read order when bypassed
        use_byp = 1'b1;
        obs.delete();
        for (int i = 0; i < N; i++) send(DW'(i));
        wait_drain();
        chk("byp_count", 32'(obs.size()), 32'(N));
        for (int i = 0; i < N && i < obs.size(); i++) begin
            chk("byp_data", 32'(obs[i].d), 32'(i));
            chk("byp_last", 32'(obs[i].l), 32'(i == N - 1));
        end
        use_byp = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
